// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite scheduler and the per-slot sprite renderers.
package sprite_pkg;

    localparam int NUM_SPRITES = 8;
    localparam int NUM_SLOTS   = 4;
    localparam int SPRITE_H    = 16;
    localparam int COORD_W     = 10;
    localparam int PAT_W       = 4;
    localparam int ROW_W       = $clog2(SPRITE_H);
    localparam int ATTR_W      = 1 + 2 * COORD_W + PAT_W;

    // Host-visible attribute record; its packed layout matches i_attr_data.
    typedef struct packed {
        logic               enable;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [PAT_W-1:0]   pattern;
    } sprite_attr_t;

    // What a renderer needs to draw one sprite on the scheduled line.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [ROW_W-1:0]   row;
        logic [PAT_W-1:0]   pattern;
    } slot_desc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// Bus between host/timing generator and the sprite scheduler.
// Handshake: i_line_start is a one-cycle request, honoured only while
// o_busy=0; o_done is a one-cycle completion pulse after which the slot
// outputs are stable until the next o_done. Attribute writes have no
// back-pressure: i_attr_we is accepted on every edge.
interface sprite_scheduler_if #(
    parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
    parameter int NUM_SLOTS   = sprite_pkg::NUM_SLOTS,
    parameter int SPRITE_H    = sprite_pkg::SPRITE_H,
    parameter int COORD_W     = sprite_pkg::COORD_W,
    parameter int PAT_W       = sprite_pkg::PAT_W
);
    logic                                   i_attr_we;
    logic [$clog2(NUM_SPRITES)-1:0]         i_attr_addr;
    logic [1+2*COORD_W+PAT_W-1:0]           i_attr_data;
    logic                                   i_line_start;
    logic [COORD_W-1:0]                     i_next_line;
    logic                                   o_busy;
    logic                                   o_done;
    logic                                   o_overflow;
    logic [NUM_SLOTS-1:0]                   o_slot_valid;
    logic [NUM_SLOTS*COORD_W-1:0]           o_slot_x;
    logic [NUM_SLOTS*$clog2(SPRITE_H)-1:0]  o_slot_row;
    logic [NUM_SLOTS*PAT_W-1:0]             o_slot_pattern;
    logic [1:0]                             o_dbg_state;

    modport master (
        output i_attr_we, i_attr_addr, i_attr_data, i_line_start, i_next_line,
        input  o_busy, o_done, o_overflow, o_slot_valid, o_slot_x, o_slot_row,
               o_slot_pattern, o_dbg_state
    );

    modport slave (
        input  i_attr_we, i_attr_addr, i_attr_data, i_line_start, i_next_line,
        output o_busy, o_done, o_overflow, o_slot_valid, o_slot_x, o_slot_row,
               o_slot_pattern, o_dbg_state
    );

endinterface

// File: rtl/sprite_hit_check.sv
// Combinational test of one attribute entry against the scheduled line,
// plus the row within the sprite that line falls on.
module sprite_hit_check #(
    parameter int COORD_W  = 10,
    parameter int SPRITE_H = 16,
    parameter int ROW_W    = $clog2(SPRITE_H)
) (
    input  logic               enable_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] line_i,
    output logic               hit_o,
    output logic [ROW_W-1:0]   row_o
);

    // One extra bit catches the borrow when the sprite starts below the line;
    // there is no vertical wrap, so a borrow is never a hit.
    logic [COORD_W:0] diff;

    // Hit when enabled, no borrow, and the offset fits inside the sprite height.
    always_comb begin
        diff  = {1'b0, line_i} - {1'b0, y_i};
        hit_o = enable_i && !diff[COORD_W] && (diff[COORD_W-1:ROW_W] == '0);
        row_o = diff[ROW_W-1:0];
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table during horizontal
// blank and publishes up to NUM_SLOTS slot descriptors for the next line.
module sprite_scheduler #(
    parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
    parameter int NUM_SLOTS   = sprite_pkg::NUM_SLOTS,
    parameter int SPRITE_H    = sprite_pkg::SPRITE_H,
    parameter int COORD_W     = sprite_pkg::COORD_W,
    parameter int PAT_W       = sprite_pkg::PAT_W
) (
    input  logic                i_pix_clk,
    input  logic                i_reset_n,
    sprite_scheduler_if.slave   bus
);
    import sprite_pkg::*;

    localparam int IDX_W  = $clog2(NUM_SPRITES);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int ATTR_W = 1 + 2 * COORD_W + PAT_W;

    // Attribute table in flops so the scan can read any entry in one cycle.
    logic [NUM_SPRITES-1:0] en_q;
    logic [COORD_W-1:0]     x_q   [NUM_SPRITES];
    logic [COORD_W-1:0]     y_q   [NUM_SPRITES];
    logic [PAT_W-1:0]       pat_q [NUM_SPRITES];

    // Scan control and working slot set.
    sched_state_t                 state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [COORD_W-1:0]           line_q;
    logic [NUM_SLOTS-1:0]         wvalid_q;
    logic [NUM_SLOTS*COORD_W-1:0] wx_q;
    logic [NUM_SLOTS*ROW_W-1:0]   wrow_q;
    logic [NUM_SLOTS*PAT_W-1:0]   wpat_q;
    logic                         wovf_q;

    // Published outputs; only COMMIT writes them.
    logic                         busy_q;
    logic                         done_q;
    logic                         ovf_q;
    logic [NUM_SLOTS-1:0]         valid_q;
    logic [NUM_SLOTS*COORD_W-1:0] ox_q;
    logic [NUM_SLOTS*ROW_W-1:0]   orow_q;
    logic [NUM_SLOTS*PAT_W-1:0]   opat_q;

    logic                         hit;
    logic [ROW_W-1:0]             hit_row;
    logic                         free_found;
    logic [SLOT_W-1:0]            free_idx;

    logic                         wr_en;
    logic [COORD_W-1:0]           wr_x;
    logic [COORD_W-1:0]           wr_y;
    logic [PAT_W-1:0]             wr_pat;

    assign wr_en  = bus.i_attr_data[ATTR_W-1];
    assign wr_x   = bus.i_attr_data[PAT_W+COORD_W +: COORD_W];
    assign wr_y   = bus.i_attr_data[PAT_W +: COORD_W];
    assign wr_pat = bus.i_attr_data[0 +: PAT_W];

    // Host writes land on the next edge regardless of scan state.
    always_ff @(posedge i_pix_clk) begin
        if (!i_reset_n) begin
            en_q <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                pat_q[i] <= '0;
            end
        end else if (bus.i_attr_we) begin
            en_q[bus.i_attr_addr]  <= wr_en;
            x_q[bus.i_attr_addr]   <= wr_x;
            y_q[bus.i_attr_addr]   <= wr_y;
            pat_q[bus.i_attr_addr] <= wr_pat;
        end
    end

    sprite_hit_check #(
        .COORD_W  (COORD_W),
        .SPRITE_H (SPRITE_H),
        .ROW_W    (ROW_W)
    ) u_hit (
        .enable_i (en_q[idx_q]),
        .y_i      (y_q[idx_q]),
        .line_i   (line_q),
        .hit_o    (hit),
        .row_o    (hit_row)
    );

    // Lowest-numbered free working slot, so earlier entries fill earlier slots.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!wvalid_q[s]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(s);
            end
        end
    end

    // Scheduler FSM: latch line, scan one entry per cycle, publish in one edge.
    always_ff @(posedge i_pix_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            line_q   <= '0;
            wvalid_q <= '0;
            wx_q     <= '0;
            wrow_q   <= '0;
            wpat_q   <= '0;
            wovf_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= '0;
            ox_q     <= '0;
            orow_q   <= '0;
            opat_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.i_line_start) begin
                        line_q   <= bus.i_next_line;
                        idx_q    <= '0;
                        wvalid_q <= '0;
                        wx_q     <= '0;
                        wrow_q   <= '0;
                        wpat_q   <= '0;
                        wovf_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        if (free_found) begin
                            wvalid_q[free_idx]                 <= 1'b1;
                            wx_q[free_idx*COORD_W +: COORD_W]  <= x_q[idx_q];
                            wrow_q[free_idx*ROW_W +: ROW_W]    <= hit_row;
                            wpat_q[free_idx*PAT_W +: PAT_W]    <= pat_q[idx_q];
                        end else begin
                            wovf_q <= 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    valid_q <= wvalid_q;
                    ox_q    <= wx_q;
                    orow_q  <= wrow_q;
                    opat_q  <= wpat_q;
                    ovf_q   <= wovf_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_slot_valid   = valid_q;
    assign bus.o_slot_x       = ox_q;
    assign bus.o_slot_row     = orow_q;
    assign bus.o_slot_pattern = opat_q;
    assign bus.o_dbg_state    = state_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: a table of attribute writes and scans
// with hand-computed slot outputs, then multi-cycle corner sequences.
module tb_sprite_scheduler;
    import sprite_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sprite_scheduler_if bus ();

    sprite_scheduler dut (
        .i_pix_clk (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        bit           is_scan;
        logic [2:0]   addr;
        sprite_attr_t attr;
        logic [9:0]   line;
        logic [3:0]   valid;
        logic         ovf;
        logic [39:0]  x;
        logic [15:0]  row;
        logic [15:0]  pat;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_no = 0;

    function automatic vec_t wr(input int a, input bit en, input int x, input int y, input int p);
        vec_t v;
        v.is_scan        = 1'b0;
        v.addr           = 3'(a);
        v.attr.enable    = en;
        v.attr.x         = 10'(x);
        v.attr.y         = 10'(y);
        v.attr.pattern   = 4'(p);
        v.line           = '0;
        v.valid          = '0;
        v.ovf            = 1'b0;
        v.x              = '0;
        v.row            = '0;
        v.pat            = '0;
        return v;
    endfunction

    function automatic vec_t sc(input int line, input logic [3:0] valid, input logic ovf,
                                input logic [39:0] x, input logic [15:0] row, input logic [15:0] pat);
        vec_t v;
        v.is_scan = 1'b1;
        v.addr    = '0;
        v.attr    = '0;
        v.line    = 10'(line);
        v.valid   = valid;
        v.ovf     = ovf;
        v.x       = x;
        v.row     = row;
        v.pat     = pat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic write_attr(input logic [2:0] a, input sprite_attr_t d);
        @(negedge clk);
        bus.i_attr_we   = 1'b1;
        bus.i_attr_addr = a;
        bus.i_attr_data = d;
        @(negedge clk);
        bus.i_attr_we   = 1'b0;
    endtask

    // Pulse line_start; returns at the negedge inside cycle 0 of the scan.
    task automatic start_scan(input logic [9:0] line);
        @(negedge clk);
        bus.i_line_start = 1'b1;
        bus.i_next_line  = line;
        @(posedge clk);
        #1;
        edge_no = 0;
        check("busy_at_edge0", 64'(bus.o_busy), 64'd1);
        check("state_scan", 64'(bus.o_dbg_state), 64'(SCAN));
        @(negedge clk);
        bus.i_line_start = 1'b0;
    endtask

    // Bounded wait for o_done; reports the edge number or -1.
    task automatic wait_done(output int at);
        at = -1;
        while (edge_no < 20) begin
            step();
            if (bus.o_done) begin
                at = edge_no;
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] valid, input logic ovf,
                                 input logic [39:0] x, input logic [15:0] row, input logic [15:0] pat);
        check({tag, ".valid"}, 64'(bus.o_slot_valid), 64'(valid));
        check({tag, ".ovf"}, 64'(bus.o_overflow), 64'(ovf));
        check({tag, ".x"}, 64'(bus.o_slot_x), 64'(x));
        check({tag, ".row"}, 64'(bus.o_slot_row), 64'(row));
        check({tag, ".pat"}, 64'(bus.o_slot_pattern), 64'(pat));
    endtask

    task automatic run_scan(input string tag, input vec_t v);
        int at;
        start_scan(v.line);
        wait_done(at);
        check({tag, ".done_edge"}, 64'(at), 64'd9);
        check({tag, ".busy_done"}, 64'(bus.o_busy), 64'd0);
        check_outputs(tag, v.valid, v.ovf, v.x, v.row, v.pat);
        step();
        check({tag, ".done_low"}, 64'(bus.o_done), 64'd0);
    endtask

    // Hard stop in case something upstream wedges the simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int dones;

        rst_n            = 1'b0;
        bus.i_attr_we    = 1'b0;
        bus.i_attr_addr  = '0;
        bus.i_attr_data  = '0;
        bus.i_line_start = 1'b0;
        bus.i_next_line  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 64'(bus.o_busy), 64'd0);
        check("rst.done", 64'(bus.o_done), 64'd0);
        check("rst.state", 64'(bus.o_dbg_state), 64'(IDLE));
        check_outputs("rst", 4'b0000, 1'b0, 40'd0, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back(sc(0, 4'b0000, 1'b0, 40'd0, 16'h0, 16'h0));
        vecs.push_back(wr(2, 1'b1, 100, 50, 3));
        vecs.push_back(sc(65, 4'b0001, 1'b0, 40'd100, 16'h000F, 16'h0003));
        vecs.push_back(sc(66, 4'b0000, 1'b0, 40'd0, 16'h0, 16'h0));
        vecs.push_back(sc(49, 4'b0000, 1'b0, 40'd0, 16'h0, 16'h0));
        vecs.push_back(sc(50, 4'b0001, 1'b0, 40'd100, 16'h0000, 16'h0003));
        for (int i = 0; i < 6; i++) vecs.push_back(wr(i, 1'b1, 10 * (i + 1), 10, i + 1));
        vecs.push_back(sc(12, 4'b1111, 1'b1, {10'd40, 10'd30, 10'd20, 10'd10}, 16'h2222, 16'h4321));
        vecs.push_back(wr(5, 1'b1, 60, 30, 6));
        vecs.push_back(sc(30, 4'b0001, 1'b0, 40'd60, 16'h0000, 16'h0006));
        vecs.push_back(wr(7, 1'b1, 500, 1020, 7));
        vecs.push_back(sc(1023, 4'b0001, 1'b0, 40'd500, 16'h0003, 16'h0007));
        vecs.push_back(wr(4, 1'b0, 50, 10, 5));
        vecs.push_back(sc(25, 4'b1111, 1'b0, {10'd40, 10'd30, 10'd20, 10'd10}, 16'hFFFF, 16'h4321));
        vecs.push_back(wr(2, 1'b0, 30, 10, 3));
        vecs.push_back(wr(3, 1'b0, 40, 10, 4));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_scan) run_scan($sformatf("vec%0d", i), vecs[i]);
            else                 write_attr(vecs[i].addr, vecs[i].attr);
        end

        // Writes during a scan: entry 7 is rewritten before it is examined,
        // entry 0 after it was examined.
        start_scan(10'd20);
        step(); step(); step();
        @(negedge clk);
        bus.i_attr_we   = 1'b1;
        bus.i_attr_addr = 3'd7;
        bus.i_attr_data = {1'b1, 10'd700, 10'd20, 4'd9};
        step();
        @(negedge clk);
        bus.i_attr_addr = 3'd0;
        bus.i_attr_data = {1'b0, 10'd10, 10'd10, 4'd1};
        step();
        @(negedge clk);
        bus.i_attr_we   = 1'b0;
        wait_done(at);
        check("midwr.done_edge", 64'(at), 64'd9);
        check_outputs("midwr", 4'b0111, 1'b0, {10'd0, 10'd700, 10'd20, 10'd10}, 16'h00AA, 16'h0921);
        run_scan("midwr_next", sc(20, 4'b0011, 1'b0, {10'd0, 10'd0, 10'd700, 10'd20}, 16'h000A, 16'h0092));

        // Second line_start while busy must be ignored.
        start_scan(10'd30);
        step(); step(); step(); step();
        @(negedge clk);
        bus.i_line_start = 1'b1;
        bus.i_next_line  = 10'd10;
        step();
        @(negedge clk);
        bus.i_line_start = 1'b0;
        wait_done(at);
        check("dbl.done_edge", 64'(at), 64'd9);
        check_outputs("dbl", 4'b0011, 1'b0, {10'd0, 10'd0, 10'd700, 10'd60}, 16'h00A0, 16'h0096);
        dones = 0;
        repeat (15) begin
            step();
            if (bus.o_done) dones++;
        end
        check("dbl.extra_done", 64'(dones), 64'd0);
        check("dbl.busy_idle", 64'(bus.o_busy), 64'd0);

        // Reset in the middle of a scan.
        start_scan(10'd30);
        repeat (5) step();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        check("mrst.busy", 64'(bus.o_busy), 64'd0);
        check("mrst.done", 64'(bus.o_done), 64'd0);
        check("mrst.state", 64'(bus.o_dbg_state), 64'(IDLE));
        check_outputs("mrst", 4'b0000, 1'b0, 40'd0, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            step();
            if (bus.o_done) dones++;
        end
        check("mrst.no_done", 64'(dones), 64'd0);
        run_scan("mrst_cleared", sc(30, 4'b0000, 1'b0, 40'd0, 16'h0, 16'h0));
        write_attr(3'd5, {1'b1, 10'd60, 10'd30, 4'd6});
        run_scan("mrst_rewrite", sc(30, 4'b0001, 1'b0, 40'd60, 16'h0000, 16'h0006));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
